// File: rtl/key_entry_conditioner_if.sv
// -----------------------------------------------------------------------------
// key_entry_conditioner_if
//
// Groups the raw board inputs and the conditioned outputs of the key entry
// front end. Clock and reset stay plain ports on the modules.
//
// Signals:
//   Enter_n      raw Enter key, active low, bouncy   (board -> conditioner)
//   X_raw        raw switch                          (board -> conditioner)
//   EnterLevel_n debounced Enter level, active low   (conditioner -> lock)
//   EnterPulse   one-cycle strobe per accepted press (conditioner -> lock)
//   XSample      switch value captured at the press  (conditioner -> lock)
//   EntryCount   accepted presses, saturating        (conditioner -> display)
//   History      entered bits, newest at bit 0       (conditioner -> display)
//   Abort        one-cycle entry timeout strobe      (conditioner -> lock)
//
// Modports:
//   master - the side that owns the raw inputs (board / testbench)
//   slave  - the conditioner itself
// -----------------------------------------------------------------------------
interface key_entry_conditioner_if #(
    parameter int SEQ_LEN = 7
);
    logic               Enter_n;
    logic               X_raw;
    logic               EnterLevel_n;
    logic               EnterPulse;
    logic               XSample;
    logic [2:0]         EntryCount;
    logic [SEQ_LEN-1:0] History;
    logic               Abort;

    modport master (
        output Enter_n,
        output X_raw,
        input  EnterLevel_n,
        input  EnterPulse,
        input  XSample,
        input  EntryCount,
        input  History,
        input  Abort
    );

    modport slave (
        input  Enter_n,
        input  X_raw,
        output EnterLevel_n,
        output EnterPulse,
        output XSample,
        output EntryCount,
        output History,
        output Abort
    );
endinterface

// File: rtl/key_entry_conditioner.sv
// -----------------------------------------------------------------------------
// key_entry_conditioner
//
// Front end between the raw Enter key / X switch and the digital lock FSM.
// Both inputs pass through 2-flop synchronisers; the key is then debounced by
// a four-state FSM so that each physical press yields exactly one EnterPulse,
// a clean EnterLevel_n and a stable XSample. Accepted bits are also collected
// into a saturating EntryCount and a History shift register for display.
//
// Ports:
//   Clock    system clock (50 MHz)
//   Reset_n  asynchronous active-low reset
//   io       key_entry_conditioner_if.slave (raw inputs in, conditioned out)
//
// Optional feature (macro ENTRY_TIMEOUT_EN):
//   When defined, an idle timer runs while entries are pending and the key is
//   released; on expiry Abort strobes for one cycle and EntryCount/History
//   clear. When undefined, Abort is constant 0.
// -----------------------------------------------------------------------------
module key_entry_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20,
    parameter int SEQ_LEN         = 7,
    parameter int TIMEOUT_CYCLES  = 250000000,
    parameter int TO_WIDTH        = 28
) (
    input logic                   Clock,
    input logic                   Reset_n,
    key_entry_conditioner_if.slave io
);

    // Elaboration-time sanity checks on the configuration.
    if (DEBOUNCE_CYCLES < 1 ||
        longint'(DEBOUNCE_CYCLES) - 1 >= (longint'(1) << CNT_WIDTH)) begin : g_bad_cnt
        $error("CNT_WIDTH too small for DEBOUNCE_CYCLES");
    end
    if (TIMEOUT_CYCLES < 1 ||
        longint'(TIMEOUT_CYCLES) - 1 >= (longint'(1) << TO_WIDTH)) begin : g_bad_to
        $error("TO_WIDTH too small for TIMEOUT_CYCLES");
    end
    // EntryCount is a 3-bit display field, so the history depth is bounded.
    if (SEQ_LEN < 2 || SEQ_LEN > 7) begin : g_bad_seq
        $error("SEQ_LEN must be in 2..7");
    end

    localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]           COUNT_MAX = 3'(SEQ_LEN);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers. The key idles high (released), the switch idles low.
    // ------------------------------------------------------------------
    logic key_meta, key_sync;
    logic x_meta,   x_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, which is what makes the 2-flop chain a chain.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            x_meta   <= 1'b0;
            x_sync   <= 1'b0;
        end else begin
            key_meta <= io.Enter_n;
            key_sync <= key_meta;
            x_meta   <= io.X_raw;
            x_sync   <= x_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t               state, next_state;
    logic [CNT_WIDTH-1:0] db_cnt;
    logic                 cnt_inc;
    logic                 accept;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= RELEASED;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        cnt_inc    = 1'b0;
        accept     = 1'b0;
        unique case (state)
            RELEASED: begin
                if (!key_sync) next_state = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (key_sync) begin
                    next_state = RELEASED;
                end else if (db_cnt == DB_LAST) begin
                    next_state = PRESSED;
                    accept     = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            PRESSED: begin
                if (key_sync) next_state = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (!key_sync) begin
                    next_state = PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    next_state = RELEASED;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: next_state = RELEASED;
        endcase
    end

    // The counter is cleared on every state change, so each wait state
    // starts from zero and the count never passes DB_LAST.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            db_cnt <= '0;
        end else if (next_state != state) begin
            db_cnt <= '0;
        end else if (cnt_inc) begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Entry timeout
    // ------------------------------------------------------------------
    logic [2:0] entry_count;
    logic       to_hit;

`ifdef ENTRY_TIMEOUT_EN
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TO_WIDTH-1:0] to_cnt;
    logic                to_run;

    assign to_run = (entry_count != 3'd0) && (state == RELEASED);
    // A press on the expiry cycle takes priority over the abort.
    assign to_hit = to_run && (to_cnt == TO_LAST) && !accept;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            to_cnt <= '0;
        end else if (accept || !to_run || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registered outputs, updated on the same edge as the FSM transition.
    // ------------------------------------------------------------------
    logic               level_n;
    logic               pulse;
    logic               x_sample;
    logic [SEQ_LEN-1:0] history;
    logic               abort;

    // NOTE: the history shift register is ordinary control state seen by the
    // display, so it takes the reset like every other flop here.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            level_n     <= 1'b1;
            pulse       <= 1'b0;
            x_sample    <= 1'b0;
            entry_count <= 3'd0;
            history     <= '0;
            abort       <= 1'b0;
        end else begin
            level_n <= !((next_state == PRESSED) || (next_state == RELEASE_WAIT));
            pulse   <= accept;
            abort   <= to_hit;
            if (accept) begin
                x_sample <= x_sync;
                history  <= {history[SEQ_LEN-2:0], x_sync};
                if (entry_count != COUNT_MAX) begin
                    entry_count <= entry_count + 3'd1;
                end
            end else if (to_hit) begin
                entry_count <= 3'd0;
                history     <= '0;
            end
        end
    end

    assign io.EnterLevel_n = level_n;
    assign io.EnterPulse   = pulse;
    assign io.XSample      = x_sample;
    assign io.EntryCount   = entry_count;
    assign io.History      = history;
    assign io.Abort        = abort;

endmodule

// File: doc/key_entry_conditioner.md
Name: key_entry_conditioner

Overview:
- Front-end stage between the raw DE1-SoC inputs (KEY1 and SW0) and the digital lock FSM.
- Synchronises and debounces the Enter key and produces the following:
  - a clean active-low Enter level and a one-cycle press strobe;
  - the switch value captured at the accepted press;
  - an entry count and a shift history of entered bits, for HEX/LED display.
- The lock FSM then sees exactly one Enter edge per physical press, paired with a stable X.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles the synced key must hold a new level before it is accepted (20 ms at 50 MHz).
- CNT_WIDTH, 20: debounce counter width; must hold DEBOUNCE_CYCLES.
- SEQ_LEN, 7: history depth in bits; also the saturation value of EntryCount.
- TIMEOUT_CYCLES, 250000000: idle-entry timeout in cycles (5 s); used only with the optional feature.
- TO_WIDTH, 28: timeout counter width.

Ports:
- Clock, input, 1: system clock, 50 MHz.
- Reset_n, input, 1: asynchronous, active-low reset.
- Enter_n, input, 1: raw Enter key, active low, asynchronous, bouncy.
- X_raw, input, 1: raw switch, asynchronous.
- EnterLevel_n, output, 1: debounced Enter level, active low; drives the lock's Enter.
- EnterPulse, output, 1: one-cycle strobe on each accepted press.
- XSample, output, 1: X value captured at the accepted press.
- EntryCount, output, 3: accepted presses since reset or abort; saturates at SEQ_LEN.
- History, output, SEQ_LEN: shift register of entered bits; newest bit at bit 0.
- Abort, output, 1: one-cycle strobe on entry timeout; tied 0 when the optional feature is off.

Behaviour:
- Reset (Reset_n=0, asynchronous) sets the following:
  - EnterLevel_n=1, EnterPulse=0, XSample=0, EntryCount=0, History=0, Abort=0;
  - both synchroniser chains to 1 (key) and 0 (switch);
  - debounce FSM to RELEASED, all counters to 0.
- Synchronisers: 2-flop chains on Enter_n and X_raw. Synced values lag the raw inputs by 2 cycles.
- Debounce FSM states:
  - RELEASED:
    - synced key=0 → go to PRESS_WAIT and clear the counter.
  - PRESS_WAIT:
    - synced key=1 → return to RELEASED;
    - else increment the counter;
    - when the counter reaches DEBOUNCE_CYCLES-1 with key still 0 → go to PRESSED.
  - PRESSED:
    - synced key=1 → go to RELEASE_WAIT and clear the counter.
  - RELEASE_WAIT:
    - synced key=0 → return to PRESSED;
    - counter reaches DEBOUNCE_CYCLES-1 with key still 1 → go to RELEASED.
- Registered outputs, one cycle after the transition:
  - EnterLevel_n=0 while in PRESSED or RELEASE_WAIT, 1 otherwise.
  - On the PRESS_WAIT→PRESSED transition, in the same cycle:
    - EnterPulse=1 for exactly one cycle;
    - XSample takes the synced X;
    - History shifts left with XSample in at bit 0;
    - EntryCount increments, saturating at SEQ_LEN; History keeps shifting after saturation.
- XSample stays valid and stable until the next accepted press. The lock samples X on EnterLevel_n's falling edge, which is when XSample is already updated.
- Glitches shorter than DEBOUNCE_CYCLES produce no pulse and no level change.
- No auto-repeat: holding the key gives exactly one EnterPulse.
- Switch changes while the key is held have no effect on XSample.
- Reset asserted mid-debounce or while held:
  - all state clears immediately;
  - after release of reset, a key still held low must pass a full PRESS_WAIT before it is accepted.
- Counters never wrap; each is cleared on every state entry.

Optional Feature:
- Macro ENTRY_TIMEOUT_EN.
- Defined:
  - a timeout counter runs while EntryCount≠0 and the FSM is RELEASED;
  - it clears on every accepted press;
  - on reaching TIMEOUT_CYCLES-1: Abort pulses 1 for one cycle, and EntryCount and History clear on the same cycle;
  - if an accepted press lands on the timeout cycle, the press wins and no Abort is raised.
- Undefined: the counter logic is absent, Abort is constant 0, and EntryCount/History clear only on reset.

Test Plan (DEBOUNCE_CYCLES=8, TIMEOUT_CYCLES=64, SEQ_LEN=7):
- Clean press: X_raw=1, Enter_n low for 20 cycles → EnterPulse high for exactly 1 cycle, 2+8+1 cycles after the falling edge; XSample=1; EntryCount=1; History=7'b0000001; EnterLevel_n low until 2+8+1 cycles after release.
- Bounce: Enter_n toggles every 3 cycles for 30 cycles, then stays low → exactly one EnterPulse, timed from the final settle; no EnterLevel_n change during the bounce.
- Sequence 1,1,1,0,1,1,1 with clean presses → History=7'b1110111; EntryCount=7. An eighth press with X=0 gives History=7'b1101110 with EntryCount still 7.
- Hold: Enter_n low for 200 cycles while X_raw toggles → one EnterPulse; XSample keeps the value from the accept cycle.
- Reset mid-PRESS_WAIT: assert Reset_n at debounce count 4 with the key still held → all outputs reset at once; after reset is released, the pulse appears only after a full 2+8+1 cycles.
- ENTRY_TIMEOUT_EN: one press, then idle for 64 cycles → Abort=1 for one cycle; EntryCount=0; History=0. With the macro undefined, Abort stays 0 and EntryCount stays 1.
